mips_bus_mem: RTL and testbench

//  Parametrised word-addressed RAM slave on the CPU's Avalon-style bus (address/read/write/waitrequest/byteenable).

---
 rtl/mips_bus_pkg.sv | 31 +++
 rtl/bus_wait_lfsr.sv | 32 +++
 rtl/mips_bus_mem.sv | 129 ++++++++++++
 tb/tb_mips_bus_mem.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_bus_pkg.sv
// Shared types and helpers for the CPU bench memory on the Avalon-style bus.
// Imported by mips_bus_mem and bus_wait_lfsr.
package mips_bus_pkg;

    localparam logic [31:0] BOOT_VECTOR = 32'hBFC00000;

    typedef enum logic {
        IDLE,
        STALL
    } bus_state_t;

    typedef enum logic {
        WAIT_FIXED,
        WAIT_RANDOM
    } wait_mode_t;

    // Replace only the byte lanes whose enable bit is set.
    function automatic logic [31:0] be_merge(
        input logic [31:0] old_word,
        input logic [31:0] new_word,
        input logic [3:0]  be
    );
        logic [31:0] merged;
        merged = old_word;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) merged[8*i +: 8] = new_word[8*i +: 8];
        end
        return merged;
    endfunction

endpackage

// File: rtl/bus_wait_lfsr.sv
// 8-bit LFSR (x^8+x^6+x^5+x^4+1) producing a reproducible stall count 0..MAX_WAIT.
// Advances only when the bus accepts an access; MAX_WAIT must stay below 255.
module bus_wait_lfsr
    import mips_bus_pkg::*;
#(
    parameter int MAX_WAIT = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] i_seed,
    input  logic       i_advance,
    output logic [7:0] o_count
);

    logic [7:0] r_lfsr;
    logic       w_feedback;

    // Taps at x^8, x^6, x^5, x^4, shifting towards the MSB.
    assign w_feedback = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_lfsr <= i_seed;
        end else if (i_advance) begin
            r_lfsr <= {r_lfsr[6:0], w_feedback};
        end
    end

    assign o_count = r_lfsr % 8'(MAX_WAIT + 1);

endmodule

// File: rtl/mips_bus_mem.sv
// Word-addressed RAM slave for the CPU's Avalon-style bus with fixed or pseudo-random
// wait states, byte-lane writes, read-before-write and a sticky error flag.
module mips_bus_mem
    import mips_bus_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = BOOT_VECTOR,
    parameter int          DEPTH_WORDS = 64,
    parameter string       INIT_FILE   = "",
    parameter int          WAIT_MODE   = 0,
    parameter int          WAIT_CYCLES = 0,
    parameter int          MAX_WAIT    = 3,
    parameter logic [7:0]  LFSR_SEED   = 8'hA5,
    parameter bit          LEGACY_BE0  = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] address,
    input  logic        write,
    input  logic        read,
    output logic        waitrequest,
    input  logic [31:0] writedata,
    input  logic [3:0]  byteenable,
    output logic [31:0] readdata,
    output logic        err,
    input  logic [31:0] dbg_addr,
    output logic [31:0] dbg_data
);

    localparam int         IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam wait_mode_t MODE  = (WAIT_MODE == 1) ? WAIT_RANDOM : WAIT_FIXED;

    logic [31:0] r_mem [DEPTH_WORDS];
    bus_state_t  r_state, w_next_state;
    logic [7:0]  r_cnt, w_next_cnt;
    logic [31:0] r_readdata;
    logic        r_err;

    logic        w_req, w_wait, w_accept, w_drop, w_go;
    logic [7:0]  w_n, w_rand_n;
    logic [3:0]  w_be;
    logic [31:0] w_word, w_dbg_word;
    logic        w_in_range, w_dbg_in;
    logic [IDX_W-1:0] w_idx;

    bus_wait_lfsr #(
        .MAX_WAIT (MAX_WAIT)
    ) u_lfsr (
        .clk       (clk),
        .reset     (reset),
        .i_seed    (LFSR_SEED),
        .i_advance (w_go),
        .o_count   (w_rand_n)
    );

    assign w_req      = read | write;
    assign w_n        = (MODE == WAIT_RANDOM) ? w_rand_n : 8'(WAIT_CYCLES);
    assign w_be       = (LEGACY_BE0 && byteenable == 4'b0000) ? 4'b1111 : byteenable;
    assign w_word     = (address - BASE_ADDR) >> 2;
    assign w_in_range = (address >= BASE_ADDR) && (w_word < 32'(DEPTH_WORDS));
    assign w_idx      = w_word[IDX_W-1:0];

    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        w_wait       = 1'b0;
        w_accept     = 1'b0;
        w_drop       = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_req) begin
                    if (w_n == 8'd0) begin
                        w_accept = 1'b1;
                    end else begin
                        w_wait       = 1'b1;
                        w_next_cnt   = w_n - 8'd1;
                        w_next_state = STALL;
                    end
                end
            end
            STALL: begin
                if (!w_req) begin
                    w_drop       = 1'b1;
                    w_next_state = IDLE;
                end else if (r_cnt != 8'd0) begin
                    w_wait     = 1'b1;
                    w_next_cnt = r_cnt - 8'd1;
                end else begin
                    w_accept     = 1'b1;
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    assign w_go = w_accept & ~reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_cnt      <= 8'd0;
            r_readdata <= 32'd0;
            r_err      <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_next_cnt;
            // Address 0 is the CPU's idle fetch and never raises an error.
            if (w_drop || (w_accept && !w_in_range && address != 32'd0)) r_err <= 1'b1;
            if (w_accept && read) r_readdata <= w_in_range ? r_mem[w_idx] : 32'd0;
        end
    end

    // NOTE: the array is deliberately left out of reset so it maps onto RAM and survives a bus reset.
    always_ff @(posedge clk) begin
        if (w_go && write && w_in_range) begin
            r_mem[w_idx] <= be_merge(r_mem[w_idx], writedata, w_be);
        end
    end

    assign w_dbg_word = (dbg_addr - BASE_ADDR) >> 2;
    assign w_dbg_in   = (dbg_addr >= BASE_ADDR) && (w_dbg_word < 32'(DEPTH_WORDS));
    assign dbg_data   = w_dbg_in ? r_mem[w_dbg_word[IDX_W-1:0]] : 32'd0;

    assign waitrequest = w_wait & ~reset;
    assign readdata    = r_readdata;
    assign err         = r_err;

endmodule

// File: tb/tb_mips_bus_mem.sv
// Self-checking bench for mips_bus_mem: four instances cover zero/fixed/random wait states
// and both byte-enable-zero behaviours; random traffic is checked against a memory/LFSR model.
module tb_mips_bus_mem;

    localparam logic [31:0] BASE  = 32'hBFC00000;
    localparam int          DEPTH = 64;
    localparam int          N_DUT = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst       [N_DUT];
    logic [31:0] bus_addr  [N_DUT];
    logic        bus_write [N_DUT];
    logic        bus_read  [N_DUT];
    logic        bus_wait  [N_DUT];
    logic [31:0] bus_wdata [N_DUT];
    logic [3:0]  bus_be    [N_DUT];
    logic [31:0] bus_rdata [N_DUT];
    logic        bus_err   [N_DUT];
    logic [31:0] dbg_addr  [N_DUT];
    logic [31:0] dbg_data  [N_DUT];

    int n_checks = 0;
    int n_fail   = 0;

    // 0: zero wait, 1: two fixed waits, 2: zero wait with be=0000 as no-op, 3: random waits
    mips_bus_mem #(.WAIT_MODE(0), .WAIT_CYCLES(0), .LEGACY_BE0(1'b1)) u_fast (
        .clk(clk), .reset(rst[0]), .address(bus_addr[0]), .write(bus_write[0]), .read(bus_read[0]),
        .waitrequest(bus_wait[0]), .writedata(bus_wdata[0]), .byteenable(bus_be[0]),
        .readdata(bus_rdata[0]), .err(bus_err[0]), .dbg_addr(dbg_addr[0]), .dbg_data(dbg_data[0]));

    mips_bus_mem #(.WAIT_MODE(0), .WAIT_CYCLES(2), .LEGACY_BE0(1'b1)) u_slow (
        .clk(clk), .reset(rst[1]), .address(bus_addr[1]), .write(bus_write[1]), .read(bus_read[1]),
        .waitrequest(bus_wait[1]), .writedata(bus_wdata[1]), .byteenable(bus_be[1]),
        .readdata(bus_rdata[1]), .err(bus_err[1]), .dbg_addr(dbg_addr[1]), .dbg_data(dbg_data[1]));

    mips_bus_mem #(.WAIT_MODE(0), .WAIT_CYCLES(0), .LEGACY_BE0(1'b0)) u_nobe0 (
        .clk(clk), .reset(rst[2]), .address(bus_addr[2]), .write(bus_write[2]), .read(bus_read[2]),
        .waitrequest(bus_wait[2]), .writedata(bus_wdata[2]), .byteenable(bus_be[2]),
        .readdata(bus_rdata[2]), .err(bus_err[2]), .dbg_addr(dbg_addr[2]), .dbg_data(dbg_data[2]));

    mips_bus_mem #(.WAIT_MODE(1), .MAX_WAIT(3), .LFSR_SEED(8'hA5), .LEGACY_BE0(1'b1)) u_rand (
        .clk(clk), .reset(rst[3]), .address(bus_addr[3]), .write(bus_write[3]), .read(bus_read[3]),
        .waitrequest(bus_wait[3]), .writedata(bus_wdata[3]), .byteenable(bus_be[3]),
        .readdata(bus_rdata[3]), .err(bus_err[3]), .dbg_addr(dbg_addr[3]), .dbg_data(dbg_data[3]));

    task automatic sync();
        @(negedge clk);
    endtask

    // Presents one request (starting in the low clock phase) and holds it until accepted.
    task automatic bus_access(input int d, input bit rd, input bit wr, input logic [31:0] a,
                              input logic [31:0] wd, input logic [3:0] be, output int stalls);
        bus_addr[d] = a; bus_wdata[d] = wd; bus_be[d] = be;
        bus_read[d] = rd; bus_write[d] = wr;
        stalls = 0;
        forever begin
            #1;
            if (!bus_wait[d]) break;
            stalls++;
            if (stalls > 40) break;
            @(negedge clk);
        end
        @(negedge clk);
        bus_read[d] = 1'b0; bus_write[d] = 1'b0;
    endtask

    task automatic peek(input int d, input logic [31:0] a, output logic [31:0] v);
        dbg_addr[d] = a;
        #1;
        v = dbg_data[d];
    endtask

    function automatic logic [31:0] lane_mask(input logic [3:0] be);
        return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    endfunction

    task automatic test_reset();
        for (int d = 0; d < N_DUT; d++) rst[d] = 1'b1;
        repeat (3) @(negedge clk);
        for (int d = 0; d < N_DUT; d++) rst[d] = 1'b0;
        #1;
        for (int d = 0; d < N_DUT; d++) begin
            n_checks += 3;
            if (bus_wait[d] !== 1'b0) begin n_fail++; $display("FAIL reset_wait[%0d]: got %b, expected 0", d, bus_wait[d]); end
            if (bus_rdata[d] !== 32'd0) begin n_fail++; $display("FAIL reset_rdata[%0d]: got %h, expected 0", d, bus_rdata[d]); end
            if (bus_err[d] !== 1'b0) begin n_fail++; $display("FAIL reset_err[%0d]: got %b, expected 0", d, bus_err[d]); end
        end
    endtask

    task automatic test_zero_wait();
        int s;
        sync();
        bus_access(0, 1'b0, 1'b1, 32'hBFC0002C, 32'd2, 4'hF, s);
        n_checks++;
        if (s != 0) begin n_fail++; $display("FAIL zw_write_stalls: got %0d, expected 0", s); end
        bus_access(0, 1'b1, 1'b0, 32'hBFC0002C, 32'd0, 4'hF, s);
        n_checks += 2;
        if (s != 0) begin n_fail++; $display("FAIL zw_read_stalls: got %0d, expected 0", s); end
        if (bus_rdata[0] !== 32'd2) begin n_fail++; $display("FAIL zw_rdata: got %h, expected 2", bus_rdata[0]); end
    endtask

    task automatic test_addr_zero();
        int s;
        sync();
        bus_access(0, 1'b1, 1'b0, 32'h0, 32'd0, 4'hF, s);
        n_checks += 2;
        if (bus_rdata[0] !== 32'd0) begin n_fail++; $display("FAIL az_rdata: got %h, expected 0", bus_rdata[0]); end
        if (bus_err[0] !== 1'b0) begin n_fail++; $display("FAIL az_read_err: got %b, expected 0", bus_err[0]); end
        bus_access(0, 1'b0, 1'b1, 32'h0, 32'h55AA55AA, 4'hF, s);
        n_checks++;
        if (bus_err[0] !== 1'b0) begin n_fail++; $display("FAIL az_write_err: got %b, expected 0", bus_err[0]); end
    endtask

    task automatic test_fixed_wait();
        int s;
        logic [31:0] v;
        sync();
        bus_access(1, 1'b0, 1'b1, 32'hBFC00010, 32'hDEADBEEF, 4'hF, s);
        peek(1, 32'hBFC00010, v);
        n_checks += 2;
        if (s != 2) begin n_fail++; $display("FAIL fw_write_stalls: got %0d, expected 2", s); end
        if (v !== 32'hDEADBEEF) begin n_fail++; $display("FAIL fw_dbg: got %h, expected deadbeef", v); end
        sync();
        bus_access(1, 1'b1, 1'b0, 32'hBFC00010, 32'd0, 4'hF, s);
        n_checks += 2;
        if (s != 2) begin n_fail++; $display("FAIL fw_read_stalls: got %0d, expected 2", s); end
        if (bus_rdata[1] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL fw_rdata: got %h, expected deadbeef", bus_rdata[1]); end
    endtask

    task automatic test_byte_lanes();
        int s;
        logic [31:0] v;
        sync();
        bus_access(0, 1'b0, 1'b1, 32'hBFC00020, 32'h11223344, 4'hF, s);
        bus_access(0, 1'b0, 1'b1, 32'hBFC00020, 32'h0000AA00, 4'b0010, s);
        peek(0, 32'hBFC00020, v);
        n_checks++;
        if (v !== 32'h1122AA44) begin n_fail++; $display("FAIL be_0010: got %h, expected 1122aa44", v); end
        sync();
        bus_access(0, 1'b0, 1'b1, 32'hBFC00020, 32'hBBCC0000, 4'b1100, s);
        peek(0, 32'hBFC00020, v);
        n_checks++;
        if (v !== 32'hBBCCAA44) begin n_fail++; $display("FAIL be_1100: got %h, expected bbccaa44", v); end
    endtask

    task automatic test_legacy_be0();
        int s;
        logic [31:0] v;
        sync();
        bus_access(0, 1'b0, 1'b1, 32'hBFC00024, 32'h11223344, 4'hF, s);
        bus_access(0, 1'b0, 1'b1, 32'hBFC00024, 32'h12345678, 4'b0000, s);
        peek(0, 32'hBFC00024, v);
        n_checks++;
        if (v !== 32'h12345678) begin n_fail++; $display("FAIL be0_legacy: got %h, expected 12345678", v); end
        sync();
        bus_access(2, 1'b0, 1'b1, 32'hBFC00024, 32'h11223344, 4'hF, s);
        bus_access(2, 1'b0, 1'b1, 32'hBFC00024, 32'h12345678, 4'b0000, s);
        peek(2, 32'hBFC00024, v);
        n_checks++;
        if (v !== 32'h11223344) begin n_fail++; $display("FAIL be0_noop: got %h, expected 11223344", v); end
    endtask

    task automatic test_read_write();
        int s;
        logic [31:0] v;
        sync();
        bus_access(0, 1'b0, 1'b1, 32'hBFC00028, 32'hCAFEF00D, 4'hF, s);
        bus_access(0, 1'b1, 1'b1, 32'hBFC00028, 32'h0BADF00D, 4'hF, s);
        peek(0, 32'hBFC00028, v);
        n_checks += 2;
        if (bus_rdata[0] !== 32'hCAFEF00D) begin n_fail++; $display("FAIL rw_old: got %h, expected cafef00d", bus_rdata[0]); end
        if (v !== 32'h0BADF00D) begin n_fail++; $display("FAIL rw_new: got %h, expected 0badf00d", v); end
    endtask

    task automatic test_back_to_back();
        int s;
        int stall_sum;
        time t0;
        logic [31:0] data [3];
        sync();
        t0 = $time;
        stall_sum = 0;
        for (int i = 0; i < 3; i++) begin
            data[i] = $urandom | 32'h1;
            bus_access(0, 1'b0, 1'b1, BASE + 32'(4 * (40 + i)), data[i], 4'hF, s);
            stall_sum += s;
        end
        for (int i = 0; i < 3; i++) begin
            bus_access(0, 1'b1, 1'b0, BASE + 32'(4 * (40 + i)), 32'd0, 4'hF, s);
            stall_sum += s;
            n_checks++;
            if (bus_rdata[0] !== data[i]) begin n_fail++; $display("FAIL b2b_rdata[%0d]: got %h, expected %h", i, bus_rdata[0], data[i]); end
        end
        n_checks += 2;
        if (stall_sum != 0) begin n_fail++; $display("FAIL b2b_stalls: got %0d, expected 0", stall_sum); end
        if ($time - t0 != 60) begin n_fail++; $display("FAIL b2b_time: got %0t, expected 60", $time - t0); end
    endtask

    task automatic test_out_of_range();
        int s;
        logic [31:0] v;
        sync();
        bus_access(0, 1'b1, 1'b0, BASE + 32'(4 * DEPTH), 32'd0, 4'hF, s);
        n_checks += 2;
        if (bus_rdata[0] !== 32'd0) begin n_fail++; $display("FAIL oor_rdata: got %h, expected 0", bus_rdata[0]); end
        if (bus_err[0] !== 1'b1) begin n_fail++; $display("FAIL oor_err: got %b, expected 1", bus_err[0]); end
        bus_access(0, 1'b1, 1'b0, 32'hBFC0002C, 32'd0, 4'hF, s);
        peek(0, BASE + 32'(4 * DEPTH), v);
        n_checks += 3;
        if (bus_rdata[0] !== 32'd2) begin n_fail++; $display("FAIL oor_after_rdata: got %h, expected 2", bus_rdata[0]); end
        if (bus_err[0] !== 1'b1) begin n_fail++; $display("FAIL oor_sticky: got %b, expected 1", bus_err[0]); end
        if (v !== 32'd0) begin n_fail++; $display("FAIL oor_dbg: got %h, expected 0", v); end
        sync();
        bus_access(2, 1'b0, 1'b1, BASE + 32'(4 * (DEPTH - 1)), 32'hA1B2C3D4, 4'hF, s);
        peek(2, BASE + 32'(4 * (DEPTH - 1)), v);
        n_checks += 2;
        if (v !== 32'hA1B2C3D4) begin n_fail++; $display("FAIL last_word: got %h, expected a1b2c3d4", v); end
        if (bus_err[2] !== 1'b0) begin n_fail++; $display("FAIL last_word_err: got %b, expected 0", bus_err[2]); end
        sync();
        bus_access(2, 1'b0, 1'b1, BASE - 32'd4, 32'hFFFFFFFF, 4'hF, s);
        n_checks++;
        if (bus_err[2] !== 1'b1) begin n_fail++; $display("FAIL below_base_err: got %b, expected 1", bus_err[2]); end
    endtask

    task automatic test_random();
        int s, op, idx, exp_n;
        logic [31:0] mem_m [DEPTH];
        logic [31:0] wd, old, mask;
        logic [3:0]  be;
        logic [7:0]  lfsr_m;
        lfsr_m = 8'hA5;
        sync();
        for (int i = 0; i < DEPTH + 100; i++) begin
            if (i < DEPTH) begin
                op = 1; idx = i; be = 4'hF;
            end else begin
                op = int'($urandom_range(0, 2)); idx = int'($urandom_range(0, DEPTH - 1));
                be = 4'($urandom_range(0, 15));
            end
            wd = $urandom;
            exp_n = int'(lfsr_m) % 4;
            bus_access(3, op != 1, op != 0, BASE + 32'(4 * idx), wd, be, s);
            n_checks++;
            if (s != exp_n) begin n_fail++; $display("FAIL rnd_stalls[%0d]: got %0d, expected %0d", i, s, exp_n); end
            old = mem_m[idx];
            if (op != 0) begin
                mask = (be == 4'h0) ? 32'hFFFFFFFF : lane_mask(be);
                mem_m[idx] = (old & ~mask) | (wd & mask);
            end
            if (op != 1) begin
                n_checks++;
                if (bus_rdata[3] !== old) begin n_fail++; $display("FAIL rnd_rdata[%0d]: got %h, expected %h", i, bus_rdata[3], old); end
            end
            // Polynomial x^8+x^6+x^5+x^4+1: feedback is the parity of state bits 7,5,4,3.
            lfsr_m = {lfsr_m[6:0], ^(lfsr_m & 8'hB8)};
        end
        n_checks++;
        if (bus_err[3] !== 1'b0) begin n_fail++; $display("FAIL rnd_err: got %b, expected 0", bus_err[3]); end
    endtask

    task automatic test_stall_reset();
        int s;
        sync();
        bus_addr[1] = 32'hBFC00010; bus_be[1] = 4'hF; bus_read[1] = 1'b1;
        #1;
        n_checks++;
        if (bus_wait[1] !== 1'b1) begin n_fail++; $display("FAIL sr_wait_before: got %b, expected 1", bus_wait[1]); end
        @(negedge clk);
        rst[1] = 1'b1; bus_read[1] = 1'b0;
        @(negedge clk);
        rst[1] = 1'b0;
        #1;
        n_checks += 3;
        if (bus_wait[1] !== 1'b0) begin n_fail++; $display("FAIL sr_wait: got %b, expected 0", bus_wait[1]); end
        if (bus_rdata[1] !== 32'd0) begin n_fail++; $display("FAIL sr_rdata: got %h, expected 0", bus_rdata[1]); end
        if (bus_err[1] !== 1'b0) begin n_fail++; $display("FAIL sr_err: got %b, expected 0", bus_err[1]); end
        sync();
        bus_access(1, 1'b1, 1'b0, 32'hBFC00010, 32'd0, 4'hF, s);
        n_checks += 2;
        if (s != 2) begin n_fail++; $display("FAIL sr_stalls: got %0d, expected 2", s); end
        if (bus_rdata[1] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL sr_retained: got %h, expected deadbeef", bus_rdata[1]); end
    endtask

    task automatic test_drop();
        int s;
        sync();
        bus_addr[1] = 32'hBFC00010; bus_be[1] = 4'hF; bus_read[1] = 1'b1;
        #1;
        @(negedge clk);
        bus_read[1] = 1'b0;
        #1;
        n_checks++;
        if (bus_wait[1] !== 1'b0) begin n_fail++; $display("FAIL drop_wait: got %b, expected 0", bus_wait[1]); end
        @(negedge clk);
        n_checks++;
        if (bus_err[1] !== 1'b1) begin n_fail++; $display("FAIL drop_err: got %b, expected 1", bus_err[1]); end
        bus_access(1, 1'b1, 1'b0, 32'hBFC00010, 32'd0, 4'hF, s);
        n_checks++;
        if (s != 2) begin n_fail++; $display("FAIL drop_next_stalls: got %0d, expected 2", s); end
    endtask

    initial begin
        for (int d = 0; d < N_DUT; d++) begin
            rst[d] = 1'b1; bus_addr[d] = 32'd0; bus_write[d] = 1'b0; bus_read[d] = 1'b0;
            bus_wdata[d] = 32'd0; bus_be[d] = 4'h0; dbg_addr[d] = 32'd0;
        end
        test_reset();
        test_zero_wait();
        test_addr_zero();
        test_fixed_wait();
        test_byte_lanes();
        test_legacy_be0();
        test_read_write();
        test_back_to_back();
        test_out_of_range();
        test_random();
        test_stall_reset();
        test_drop();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
